// File: rtl/ls_bus_if_pkg.sv
// ----------------------------------------------------------------------------
// ls_bus_if_pkg
//   Shared definitions for the load/store external bus master and its lane
//   generator: access size codes, the 2-bit FSM state encoding and a small
//   address helper.
//   No ports (package).
// ----------------------------------------------------------------------------
package ls_bus_if_pkg;

  // Access size codes as driven by the load/store controller.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;  // behaves as a word access

  // Bus master transaction FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Rebuild a word-aligned byte address from its word index bits.
  function automatic logic [15:0] word_align(input logic [13:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/ls_bus_if_if.sv
// ----------------------------------------------------------------------------
// ls_bus_if_if
//   Peripheral-bus signal bundle between the load/store bus master and a
//   slave. Single request/ready handshake, 16-bit word-aligned address,
//   32-bit data with byte lane enables.
//   Signals:
//     bus_req   master->slave  request, held until bus_rdy or timeout
//     bus_we    master->slave  write qualifier
//     bus_addr  master->slave  word-aligned byte address
//     bus_be    master->slave  byte lane enables
//     bus_wdata master->slave  lane-aligned store data
//     bus_rdata slave->master  read data, valid with bus_rdy
//     bus_rdy   slave->master  completion
// ----------------------------------------------------------------------------
interface ls_bus_if_if;

  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rdy;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_rdy
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_rdy
  );

endinterface

// File: rtl/ls_bus_lane_gen.sv
// ----------------------------------------------------------------------------
// ls_bus_lane_gen
//   Purely combinational byte-lane generator. From the access size, the low
//   two address bits and right-aligned store data it produces the 4-bit
//   lane enable and the store word with the data replicated into every lane
//   it could land in. Shared with the PRAM store path.
//   Ports:
//     size_i     in  2   access size code (00 byte, 01 half, 1x word)
//     addr_lo_i  in  2   byte offset within the word
//     wr_data_i  in  32  right-aligned store data
//     be_o       out 4   byte lane enables
//     wdata_o    out 32  lane-aligned store data
// ----------------------------------------------------------------------------
module ls_bus_lane_gen
  import ls_bus_if_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wr_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wr_data_i[7:0]}};
      end
      SZ_HALF: begin
        // Odd half-word offsets are not trapped; bit 0 is simply ignored.
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wr_data_i[15:0]}};
      end
      SZ_WORD, SZ_RSVD: begin
        be_o    = 4'b1111;
        wdata_o = wr_data_i;
      end
      default: begin
        be_o    = '0;
        wdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/ls_bus_if.sv
// ----------------------------------------------------------------------------
// ls_bus_if
//   External data-bus master for the load/store path. Captures one request
//   from the load/store controller, runs a single request/ready transaction
//   on the peripheral bus, and returns the read word with a one-cycle ack.
//   A slave that never answers is cut off after TIMEOUT_CYCLES cycles in REQ
//   and reported through bus_err together with the ack.
//   Ports:
//     clk             in   1   system clock, rising edge
//     res_n           in   1   synchronous reset, active low
//     ls_bus_en       in   1   access request (level, held until ack)
//     ls_bus_wr_en    in   1   1 = store, 0 = load
//     ls_bus_addr     in   16  byte address
//     ls_bus_wr_data  in   32  right-aligned store data
//     ls_access_size  in   2   00 byte, 01 half, 1x word
//     ext_read_data   out  32  raw read word, valid only with bus_ack
//     bus_ack         out  1   one-cycle completion pulse
//     bus_err         out  1   one-cycle timeout flag, coincident with bus_ack
//     bus             master modport of ls_bus_if_if (peripheral bus)
// ----------------------------------------------------------------------------
module ls_bus_if
  import ls_bus_if_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         ls_bus_en,
  input  logic         ls_bus_wr_en,
  input  logic [15:0]  ls_bus_addr,
  input  logic [31:0]  ls_bus_wr_data,
  input  logic [1:0]   ls_access_size,
  output logic [31:0]  ext_read_data,
  output logic         bus_ack,
  output logic         bus_err,
  ls_bus_if_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;

  ls_bus_lane_gen u_lane_gen (
    .size_i    (ls_access_size),
    .addr_lo_i (ls_bus_addr[1:0]),
    .wr_data_i (ls_bus_wr_data),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata)
  );

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ls_bus_en) begin
          // Snapshot the request so the bus stays stable for the whole
          // REQ phase regardless of what the controller does meanwhile.
          we_d    = ls_bus_wr_en;
          addr_d  = word_align(ls_bus_addr[15:2]);
          be_d    = lane_be;
          wdata_d = lane_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (bus.bus_rdy) begin
          // A ready arriving on the last allowed cycle still completes cleanly.
          rdata_d = we_q ? 32'h0 : bus.bus_rdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus outputs are only non-zero while a request is outstanding.
  logic in_req;
  assign in_req = (state_q == ST_REQ);

  assign bus.bus_req   = in_req;
  assign bus.bus_we    = in_req & we_q;
  assign bus.bus_addr  = in_req ? addr_q  : 16'h0;
  assign bus.bus_be    = in_req ? be_q    : 4'h0;
  assign bus.bus_wdata = in_req ? wdata_q : 32'h0;

  assign bus_ack       = (state_q == ST_DONE);
  assign bus_err       = bus_ack & err_q;
  assign ext_read_data = bus_ack ? rdata_q : 32'h0;

endmodule
